systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 19 +
 rtl/matrix_regfile.sv | 35 +++
 rtl/systolic_feeder.sv | 175 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder: array geometry,
// stream length, matrix-select encodings and the sequencer states.
package systolic_pkg;

    localparam int N          = 3;
    localparam int STREAM_LEN = 5;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/matrix_regfile.sv
// One 3x3 operand matrix held in registers, written one element at a time
// by row-major index; indices beyond the last element are dropped.
module matrix_regfile
    import systolic_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [DW-1:0]         wr_data,
    output logic [N*N*DW-1:0]     q
);

    logic [DW-1:0] mem [N*N];

    // NOTE: this storage is plain flops, not a RAM macro, so it can and must
    // take the async reset; a RAM-style array would have to be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < N*N; e++) mem[e] <= '0;
        end else if (wr_en) begin
            for (int e = 0; e < N*N; e++) begin
                if (wr_addr == 4'(e)) mem[e] <= wr_data;
            end
        end
    end

    always_comb begin
        q = '0;
        for (int e = 0; e < N*N; e++) q[e*DW +: DW] = mem[e];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Streams two stored 3x3 matrices into a 3x3 systolic array with the usual
// diagonal skew: one clear cycle, five operand steps, a zero drain, then done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DRAIN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          array_clr,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic [DW-1:0] a3,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] b3
);

    localparam int             DCW       = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
    localparam logic [2:0]     STEP_LAST = 3'(STREAM_LEN - 1);
    localparam logic [DCW-1:0] DCNT_LAST = (DRAIN > 0) ? DCW'(DRAIN - 1) : '0;

    state_t         state, state_n;
    logic [2:0]     step, step_n;
    logic [DCW-1:0] dcnt, dcnt_n;

    logic           busy_n, done_n, clr_n;
    logic [DW-1:0]  a_n [N];
    logic [DW-1:0]  b_n [N];
    logic [DW-1:0]  a_q [N];
    logic [DW-1:0]  b_q [N];
    logic [2:0]     diff;

    logic [N*N*DW-1:0] a_flat, b_flat;
    logic [DW-1:0]     a_mat [N][N];
    logic [DW-1:0]     b_mat [N][N];

    logic we_a, we_b;

    // Busy is registered, so a write landing with start in IDLE still commits.
    assign we_a = wr_en && !busy && (wr_sel == SEL_A);
    assign we_b = wr_en && !busy && (wr_sel == SEL_B);

    matrix_regfile #(.DW(DW)) u_mat_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (we_a),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .q       (a_flat)
    );

    matrix_regfile #(.DW(DW)) u_mat_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (we_b),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .q       (b_flat)
    );

    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_mat[r][c] = a_flat[(r*N + c)*DW +: DW];
                b_mat[r][c] = b_flat[(r*N + c)*DW +: DW];
            end
        end
    end

    // NOTE: state and output registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            step  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            dcnt  <= dcnt_n;
        end
    end

    // NOTE: every signal is given a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        step_n  = step;
        dcnt_n  = dcnt;
        diff    = '0;

        unique case (state)
            ST_IDLE: begin
                step_n = '0;
                dcnt_n = '0;
                if (start) state_n = ST_CLR;
            end
            ST_CLR: begin
                step_n  = '0;
                state_n = ST_STREAM;
            end
            ST_STREAM: begin
                if (step == STEP_LAST) begin
                    dcnt_n  = '0;
                    state_n = (DRAIN > 0) ? ST_DRAIN : ST_DONE;
                end else begin
                    step_n = step + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (dcnt == DCNT_LAST) state_n = ST_DONE;
                else                   dcnt_n  = dcnt + 1'b1;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up
        // with the cycle the state is actually in.
        busy_n = (state_n == ST_CLR) || (state_n == ST_STREAM) || (state_n == ST_DRAIN);
        done_n = (state_n == ST_DONE);
        clr_n  = (state_n == ST_CLR);

        for (int i = 0; i < N; i++) begin
            a_n[i] = '0;
            b_n[i] = '0;
        end
        if (state_n == ST_STREAM) begin
            for (int i = 0; i < N; i++) begin
                diff = step_n - 3'(i);
                if (step_n >= 3'(i) && diff < 3'(N)) begin
                    a_n[i] = a_mat[i][diff[1:0]];
                    b_n[i] = b_mat[diff[1:0]][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            array_clr <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            busy      <= busy_n;
            done      <= done_n;
            array_clr <= clr_n;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= a_n[i];
                b_q[i] <= b_n[i];
            end
        end
    end

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a DRAIN=4 and a DRAIN=0 instance share stimulus
// and are compared each cycle against a matrix-level model of the stream.
module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int VW = 6*DW + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;

    logic          busy4, done4, clr4;
    logic [DW-1:0] a1_4, a2_4, a3_4, b1_4, b2_4, b3_4;
    logic          busy0, done0, clr0;
    logic [DW-1:0] a1_0, a2_0, a3_0, b1_0, b2_0, b3_0;

    int errors = 0;
    int checks = 0;
    int ma [9];
    int mb [9];

    always #5 clk = ~clk;

    systolic_feeder #(.DW(DW), .DRAIN(4)) dut4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .busy(busy4), .done(done4), .array_clr(clr4),
        .a1(a1_4), .a2(a2_4), .a3(a3_4), .b1(b1_4), .b2(b2_4), .b3(b3_4)
    );

    systolic_feeder #(.DW(DW), .DRAIN(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .busy(busy0), .done(done0), .array_clr(clr0),
        .a1(a1_0), .a2(a2_0), .a3(a3_0), .b1(b1_0), .b2(b2_0), .b3(b3_0)
    );

    function automatic logic [VW-1:0] obs4();
        return {a1_4, a2_4, a3_4, b1_4, b2_4, b3_4, busy4, done4, clr4};
    endfunction

    function automatic logic [VW-1:0] obs0();
        return {a1_0, a2_0, a3_0, b1_0, b2_0, b3_0, busy0, done0, clr0};
    endfunction

    // Expected outputs c cycles after the start edge, for drain length d.
    function automatic logic [VW-1:0] expect_vec(int d, int c);
        logic [DW-1:0] av [3];
        logic [DW-1:0] bv [3];
        logic bz, dn, cl;
        int t, k;
        bz = 1'b0; dn = 1'b0; cl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        if (c == 1) begin
            bz = 1'b1;
            cl = 1'b1;
        end else if (c >= 2 && c <= 6) begin
            bz = 1'b1;
            t = c - 2;
            for (int i = 0; i < 3; i++) begin
                k = t - i;
                if (k >= 0 && k <= 2) begin
                    av[i] = DW'(ma[i*3 + k]);
                    bv[i] = DW'(mb[k*3 + i]);
                end
            end
        end else if (c <= 6 + d) begin
            bz = 1'b1;
        end else if (c == 7 + d) begin
            dn = 1'b1;
        end
        return {av[0], av[1], av[2], bv[0], bv[1], bv[2], bz, dn, cl};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write is sampled on the following rising edge.
    task automatic wr(input logic sel, input logic [3:0] addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = DW'(data);
        if (addr < 4'd9) begin
            if (sel) mb[addr] = data;
            else     ma[addr] = data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulses start and checks both instances for 12 cycles; at cycle junk_c a
    // write to A[0] plus a second start are driven while the stream is busy.
    task automatic run_stream(input string tag, input int junk_c);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("%s d4 c%0d", tag, c), obs4(), expect_vec(4, c));
            check($sformatf("%s d0 c%0d", tag, c), obs0(), expect_vec(0, c));
            start = 1'b0;
            wr_en = 1'b0;
            if (c == junk_c) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = DW'(99);
                start   = 1'b1;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        for (int e = 0; e < 9; e++) begin
            ma[e] = 0;
            mb[e] = 0;
        end

        // Reset state
        @(negedge clk);
        check("reset d4", obs4(), '0);
        check("reset d0", obs0(), '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle d4", obs4(), '0);
        check("idle d0", obs0(), '0);

        // Reference matrices, with an ignored write + start mid-stream
        begin
            int ra [9];
            int rb [9];
            ra = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
            rb = '{2, 1, 3, 4, 5, 7, 6, 9, 8};
            for (int e = 0; e < 9; e++) wr(1'b0, 4'(e), ra[e]);
            for (int e = 0; e < 9; e++) wr(1'b1, 4'(e), rb[e]);
        end
        run_stream("ref", 3);
        run_stream("ref_rerun", 0);

        // Out-of-range addresses change nothing
        wr(1'b0, 4'd12, 55);
        wr(1'b1, 4'd15, 55);
        run_stream("badaddr", 0);

        // Write and start in the same IDLE cycle: the stream sees the new value
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd4;
        wr_data = DW'(77);
        ma[4]   = 77;
        run_stream("wr_start", 0);

        // Random matrices
        for (int r = 0; r < 3; r++) begin
            for (int e = 0; e < 9; e++) wr(1'b0, 4'(e), int'($urandom_range(0, 255)));
            for (int e = 0; e < 9; e++) wr(1'b1, 4'(e), int'($urandom_range(0, 255)));
            run_stream($sformatf("rand%0d", r), 0);
        end

        // Reset during t2 aborts the stream and clears both matrices
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("abort d4 c%0d", c), obs4(), expect_vec(4, c));
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        check("async reset d4", obs4(), '0);
        check("async reset d0", obs0(), '0);
        for (int e = 0; e < 9; e++) begin
            ma[e] = 0;
            mb[e] = 0;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post reset d4 c%0d", c), obs4(), '0);
            check($sformatf("post reset d0 c%0d", c), obs0(), '0);
        end
        run_stream("cleared", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
